switch_alloc_3port: RTL
=======================

SWITCH_ALLOC_3PORT -- requirements
Module: switch_alloc_3port

Interface
REQ-001 Parameter: STALL_LIMIT, default 255, count of consecutive no-transfer cycles on a busy output that raises stall_err; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 valid_x / valid_y / valid_local  input  1 each  input port p presents a flit.
REQ-005 head_x / head_y / head_local  input  1 each  presented flit is a head flit.
REQ-006 tail_x / tail_y / tail_local  input  1 each  presented flit is a tail flit; head=tail=1 means a single-flit packet.
REQ-007 req_x / req_y / req_local  input  3 each  requested output, one-hot: bit0 = x, bit1 = y, bit2 = local.
REQ-008 full_x / full_y / full_local  input  1 each  downstream buffer of that output is full.
REQ-009 out_x_sw / out_y_sw / out_local_sw  output  3 each  selected input per output: SW_X1 = 3'b001, SW_Y1 = 3'b010, SW_LOCAL = 3'b100, idle = 3'b000.
REQ-010 stall_err  output  1  sticky stall-watchdog flag.

Function
REQ-011 Each output o SHALL have an independent two-state FSM with states IDLE and BUSY.
REQ-012 Outputs SHALL be registered: out_o_sw is 3'b000 in IDLE and holds the granted input's code in BUSY.
REQ-013 Input p SHALL request output o only when valid_p=1, head_p=1 and req_p is exactly one-hot with bit o set.
- Zero-hot or multi-hot req_p is not a request.
- A body or tail flit is not a request.
REQ-014 In IDLE with at least one request, the arbiter SHALL select a winner round-robin starting from output o's priority pointer (order x -> y -> local -> x).
- Next edge: FSM enters BUSY, out_o_sw = winner code, pointer advances to the input after the winner.
REQ-015 In IDLE with no request, FSM, out_o_sw and pointer SHALL stay unchanged.
REQ-016 Transfer on output o SHALL be defined as: BUSY, granted input valid = 1, and full_o = 0.
REQ-017 A transfer with tail=1 on the granted input SHALL return the FSM to IDLE, with out_o_sw = 3'b000 on the next edge.
- A head=tail single-flit packet follows the same rule.
REQ-018 In BUSY, grant SHALL be held through any number of stall cycles (valid=0 or full_o=1) until the tail transfer; new head requests for o wait.
REQ-019 Latency and turnaround:
- Head request at cycle n -> grant visible at n+1 -> earliest transfer at n+1.
- Tail transfer at cycle m -> IDLE at m+1 -> next grant visible at m+2.
REQ-020 The three outputs SHALL arbitrate independently in the same cycle; one-hot req guarantees an input is granted by at most one output.
REQ-021 Each output SHALL have an 8-bit stall counter:
- Increments each BUSY cycle without a transfer, saturating at STALL_LIMIT.
- Clears on any transfer and in IDLE.
REQ-022 When any counter equals STALL_LIMIT, stall_err SHALL be set on the next edge and remain 1 until reset.
- The grant is not revoked.
REQ-023 No combinational path SHALL exist from any input to any output.

Reset
REQ-024 On rst_n low, asynchronously and regardless of in-progress packets:
- All FSMs go to IDLE; out_x_sw = out_y_sw = out_local_sw = 3'b000.
- All priority pointers point to x.
- All stall counters = 0; stall_err = 0.
REQ-025 After rst_n deasserts, a packet interrupted by reset SHALL NOT be resumed.
- Its remaining body/tail flits are not requests and are not granted.

Verification
REQ-026 Single-flit grant: after reset, valid_x=1, head_x=tail_x=1, req_x=3'b010, full_y=0 at cycle 0 -> out_y_sw=3'b001 at cycle 1 -> transfer at cycle 1 -> out_y_sw=3'b000 at cycle 2.
REQ-027 Contention and round-robin:
- x, y and local all send head flits to local (req=3'b100) -> grants in order x (3'b001), y (3'b010), local (3'b100).
- Each held until its tail transfer, with the 1-cycle idle gap of REQ-019 between grants.
REQ-028 Wormhole hold: 4-flit packet x -> y with full_y=1 for 3 cycles mid-packet, while local sends a head to y -> out_y_sw stays 3'b001 throughout; local granted only 2 cycles after x's tail transfer.
REQ-029 Watchdog: STALL_LIMIT=4; y grant held with full_y=1 -> stall_err=1 after the counter reaches 4, stays 1 after full_y drops and the packet completes; rst_n pulse -> stall_err=0.
REQ-030 Reset mid-packet:
- rst_n low while out_x_sw=3'b010 -> all sw outputs 3'b000 immediately, pointers at x.
- Following body/tail flits from y -> no grant.
- Next head from y -> normal grant.
REQ-031 Malformed request: head with req=3'b011 or 3'b000 -> no grant on any output; all outputs remain 3'b000.

Source files
------------

// File: rtl/switch_alloc_3port.sv
// Three-output wormhole switch allocator.
// Each output owns an IDLE/BUSY FSM, a round-robin priority pointer and a
// stall watchdog counter. A head flit with a one-hot route request competes
// for its output. The grant is held until the granted input's tail flit
// transfers. Every output is driven straight from a register.
module switch_alloc_3port #(
   parameter int unsigned STALL_LIMIT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid_x,
   input  logic       valid_y,
   input  logic       valid_local,
   input  logic       head_x,
   input  logic       head_y,
   input  logic       head_local,
   input  logic       tail_x,
   input  logic       tail_y,
   input  logic       tail_local,
   input  logic [2:0] req_x,
   input  logic [2:0] req_y,
   input  logic [2:0] req_local,
   input  logic       full_x,
   input  logic       full_y,
   input  logic       full_local,
   output logic [2:0] out_x_sw,
   output logic [2:0] out_y_sw,
   output logic [2:0] out_local_sw,
   output logic       stall_err
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

   // Per-port buses, indexed x = 0, y = 1, local = 2. This index also sets
   // the bit position of the one-hot switch codes.
   logic [2:0] valid_v;
   logic [2:0] head_v;
   logic [2:0] tail_v;
   logic [2:0] full_v;
   logic [2:0] req_a [3];
   logic [2:0] stall_hit;
   logic       stall_err_q;
   logic       stall_err_d;

   assign valid_v = {valid_local, valid_y, valid_x};
   assign head_v  = {head_local,  head_y,  head_x};
   assign tail_v  = {tail_local,  tail_y,  tail_x};
   assign full_v  = {full_local,  full_y,  full_x};
   assign req_a[0] = req_x;
   assign req_a[1] = req_y;
   assign req_a[2] = req_local;

   for (genvar o = 0; o < 3; o++) begin : g_out
      localparam logic [2:0] OUT_BIT = 3'b001 << o;

      state_e     state_q, state_d;
      logic [2:0] sw_q, sw_d;
      logic [1:0] ptr_q, ptr_d;
      logic [7:0] cnt_q, cnt_d;
      logic [2:0] reqs;
      logic       xfer;
      logic       tail_xfer;

      // Request decode: a valid head flit whose route is exactly this output.
      always_comb begin
         reqs = '0;
         for (int p = 0; p < 3; p++) begin
            reqs[p] = valid_v[p] & head_v[p] & (req_a[p] == OUT_BIT);
         end
      end

      // A flit moves when the granted input presents one and downstream has room.
      assign xfer      = (state_q == ST_BUSY) & (|(sw_q & valid_v)) & ~full_v[o];
      assign tail_xfer = xfer & (|(sw_q & tail_v));

      // Next-state: round-robin pick in IDLE, release on tail transfer in BUSY.
      always_comb begin
         logic       found;
         logic [1:0] win;
         logic [2:0] sum;
         // NOTE: every variable gets a default first, so no path through
         // the block leaves one unassigned. That prevents an inferred latch.
         state_d = state_q;
         sw_d    = sw_q;
         ptr_d   = ptr_q;
         found   = 1'b0;
         win     = 2'd0;
         sum     = 3'd0;
         case (state_q)
            ST_IDLE: begin
               for (int k = 0; k < 3; k++) begin
                  sum = {1'b0, ptr_q} + 3'(k);
                  if (sum >= 3'd3) sum = sum - 3'd3;
                  if (!found && reqs[sum[1:0]]) begin
                     found = 1'b1;
                     win   = sum[1:0];
                  end
               end
               if (found) begin
                  state_d = ST_BUSY;
                  sw_d    = 3'b001 << win;
                  ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
               end
            end
            ST_BUSY: begin
               if (tail_xfer) begin
                  state_d = ST_IDLE;
                  sw_d    = 3'b000;
               end
            end
            default: begin
               state_d = ST_IDLE;
               sw_d    = 3'b000;
            end
         endcase
      end

      // Stall counter: count non-transfer BUSY cycles, saturating at the limit.
      always_comb begin
         cnt_d = cnt_q;
         if (state_q == ST_IDLE || xfer) begin
            cnt_d = 8'd0;
         end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 8'd1;
         end
      end

      assign stall_hit[o] = (cnt_q == LIMIT);

      // State register: FSM, grant code, priority pointer and stall counter.
      always_ff @(posedge clk or negedge rst_n) begin
         // NOTE: sequential state uses non-blocking assignments. All
         // registers then update together from values taken before the edge.
         if (!rst_n) begin
            state_q <= ST_IDLE;
            sw_q    <= 3'b000;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
         end else begin
            state_q <= state_d;
            sw_q    <= sw_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
         end
      end
   end

   // Sticky watchdog: once set, it stays set until reset.
   assign stall_err_d = stall_err_q | (|stall_hit);

   // Watchdog flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_err_q <= 1'b0;
      else        stall_err_q <= stall_err_d;
   end

   assign out_x_sw     = g_out[0].sw_q;
   assign out_y_sw     = g_out[1].sw_q;
   assign out_local_sw = g_out[2].sw_q;
   assign stall_err    = stall_err_q;

endmodule
